// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 nonce sequencer and its worker.
package sha256_pkg;

    typedef logic [7:0][31:0] hash_t;
    typedef logic [2:0][31:0] tail_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P2_RUN,
        S_P3_RUN,
        S_WRITE,
        S_DONE
    } state_e;

    // Word 0 is H0.
    localparam hash_t SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

endpackage

// File: rtl/sha256_pass_watchdog.sv
// Per-pass watchdog: reloads on every state entry, counts down while a pass runs,
// and flags timeout in the TIMEOUT-th cycle of the pass.
module sha256_pass_watchdog #(
    parameter int TIMEOUT = 80
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = CW'(TIMEOUT - 1);
        else if (run && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign timeout = run && (cnt_q == '0);

endmodule

// File: rtl/sha256_nonce_scheduler.sv
// Drives one SHA-256 worker through phase 2 then phase 3 for each nonce of a job,
// writes H0 per nonce, tracks the first H0 <= target, and aborts stalled passes.
module sha256_nonce_scheduler
    import sha256_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int TIMEOUT    = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  hash_t       midstate,
    input  tail_t       msg_tail,
    input  logic [31:0] target,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        worker_start,
    output logic        worker_phase_sel,
    output logic [3:0]  worker_nonce,
    output hash_t       worker_hi,
    output tail_t       worker_msg_tail,
    input  hash_t       worker_ho,
    input  logic        worker_finish,
    output logic        res_we,
    output logic [3:0]  res_idx,
    output logic [31:0] res_word,
    output logic        found,
    output logic [3:0]  found_nonce
);
    state_e      state_q, state_d;
    hash_t       mid_q, mid_d, p2_q, p2_d;
    tail_t       tail_q, tail_d;
    logic [31:0] target_q, target_d, res_word_q, res_word_d;
    logic [3:0]  nonce_q, nonce_d, found_nonce_q, found_nonce_d;
    logic        err_q, err_d, found_q, found_d;
    logic        run, wd_load, wd_timeout;

    assign run     = (state_q == S_P2_RUN) || (state_q == S_P3_RUN);
    assign wd_load = (state_d != state_q);

    sha256_pass_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (wd_load),
        .run     (run),
        .timeout (wd_timeout)
    );

    // A finish in the same cycle as the timeout wins: it is tested first.
    always_comb begin
        state_d       = state_q;
        mid_d         = mid_q;
        tail_d        = tail_q;
        target_d      = target_q;
        p2_d          = p2_q;
        nonce_d       = nonce_q;
        res_word_d    = res_word_q;
        err_d         = err_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        unique case (state_q)
            S_IDLE: if (go) begin
                mid_d         = midstate;
                tail_d        = msg_tail;
                target_d      = target;
                nonce_d       = '0;
                err_d         = 1'b0;
                found_d       = 1'b0;
                found_nonce_d = '0;
                state_d       = S_P2_RUN;
            end
            S_P2_RUN: begin
                if (worker_finish) begin
                    p2_d    = worker_ho;
                    state_d = S_P3_RUN;
                end else if (wd_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_P3_RUN: begin
                if (worker_finish) begin
                    res_word_d = worker_ho[0];
                    state_d    = S_WRITE;
                end else if (wd_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (!found_q && res_word_q <= target_q) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                end
                if (nonce_q == 4'(NUM_NONCES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    nonce_d = nonce_q + 1'b1;
                    state_d = S_P2_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            mid_q         <= '0;
            tail_q        <= '0;
            target_q      <= '0;
            p2_q          <= '0;
            nonce_q       <= '0;
            res_word_q    <= '0;
            err_q         <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
        end else begin
            state_q       <= state_d;
            mid_q         <= mid_d;
            tail_q        <= tail_d;
            target_q      <= target_d;
            p2_q          <= p2_d;
            nonce_q       <= nonce_d;
            res_word_q    <= res_word_d;
            err_q         <= err_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
        end
    end

    // Start stays high on the finish cycle so the worker parks instead of relaunching.
    assign worker_start     = !(run && !worker_finish);
    assign worker_phase_sel = (state_q == S_P3_RUN);
    assign worker_hi        = (state_q == S_P3_RUN) ? p2_q : mid_q;
    assign worker_nonce     = nonce_q;
    assign worker_msg_tail  = tail_q;

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign res_we      = (state_q == S_WRITE);
    assign res_idx     = nonce_q;
    assign res_word    = res_word_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench for sha256_nonce_scheduler: a latency-programmable worker stub with a
// deterministic digest, and a scoreboard of expected (res_idx, res_word) pairs.
module tb_sha256_nonce_scheduler;
    import sha256_pkg::*;

    localparam int NN = 16;

    logic        clk, reset_n, go;
    hash_t       midstate, worker_hi, worker_ho;
    tail_t       msg_tail, worker_msg_tail;
    logic [31:0] target, res_word;
    logic        busy, done, err, worker_start, worker_phase_sel, worker_finish;
    logic        res_we, found;
    logic [3:0]  worker_nonce, res_idx, found_nonce;

    sha256_nonce_scheduler #(.NUM_NONCES(NN), .TIMEOUT(80)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .midstate(midstate),
        .msg_tail(msg_tail), .target(target), .busy(busy), .done(done),
        .err(err), .worker_start(worker_start), .worker_phase_sel(worker_phase_sel),
        .worker_nonce(worker_nonce), .worker_hi(worker_hi),
        .worker_msg_tail(worker_msg_tail), .worker_ho(worker_ho),
        .worker_finish(worker_finish), .res_we(res_we), .res_idx(res_idx),
        .res_word(res_word), .found(found), .found_nonce(found_nonce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [3:0] idx; logic [31:0] word; } exp_t;
    exp_t sb[$];
    int   errors = 0, checks = 0, we_cnt = 0;
    int   stub_lat = 67;
    int   scnt;

    // Stand-in digest: any deterministic mix of all worker inputs works for routing checks.
    function automatic hash_t wmodel(hash_t hi, logic [3:0] n, logic ph, tail_t t);
        hash_t r;
        logic [31:0] x;
        for (int i = 0; i < 8; i++) begin
            x = hi[i] + t[i % 3] + {24'h0, n, 3'(i), ph};
            x = x ^ (x << 7) ^ (x >> 11);
            x = x * 32'h9E3779B1;
            r[i] = x ^ {x[15:0], x[31:16]};
        end
        return r;
    endfunction

    function automatic logic [31:0] h0_of(hash_t mid, tail_t tl, int n);
        hash_t p2;
        p2 = wmodel(mid, 4'(n), 1'b0, tl);
        return wmodel(p2, 4'(n), 1'b1, tl)[0];
    endfunction

    // Worker stub: finish arrives stub_lat cycles after the first start-low cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          scnt <= 0;
        else if (worker_start) scnt <= 0;
        else                   scnt <= scnt + 1;
    end
    assign worker_finish = (scnt == stub_lat);
    always_comb worker_ho = wmodel(worker_hi, worker_nonce, worker_phase_sel, worker_msg_tail);

    always @(negedge clk) begin
        if (res_we) begin
            exp_t e;
            we_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL res_unexpected idx=%0d word=%h", res_idx, res_word);
            end else begin
                e = sb.pop_front();
                if (res_idx !== e.idx || res_word !== e.word) begin
                    errors++;
                    $display("FAIL res_write got idx=%0d word=%h want idx=%0d word=%h",
                             res_idx, res_word, e.idx, e.word);
                end
            end
        end
    end

    task automatic push_job(input hash_t mid, input tail_t tl, input logic [31:0] tg,
                            output bit f, output logic [3:0] fn);
        logic [31:0] h;
        f = 1'b0; fn = '0;
        for (int n = 0; n < NN; n++) begin
            h = h0_of(mid, tl, n);
            sb.push_back('{idx: 4'(n), word: h});
            if (!f && h <= tg) begin f = 1'b1; fn = 4'(n); end
        end
    endtask

    // Returns cyc = cycle (go cycle = 0) in which done was seen, or the reset cycle.
    task automatic run_job(input hash_t mid, input tail_t tl, input logic [31:0] tg,
                           input int go2_at, input int rst_at,
                           output int cyc, output bit seen_done);
        @(posedge clk); #1;
        midstate = mid; msg_tail = tl; target = tg; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        cyc = 1; seen_done = 1'b0;
        while (cyc < 4000) begin
            if (cyc == go2_at) begin go = 1'b1; midstate = ~mid; target = ~tg; end
            if (cyc == rst_at) reset_n = 1'b0;
            @(negedge clk);
            if (cyc == rst_at) break;
            if (done) begin seen_done = 1'b1; break; end
            @(posedge clk); #1;
            go = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; go = 1'b0; midstate = '0; msg_tail = '0; target = '0;
        repeat (3) begin
            @(posedge clk); #1; go = ~go;
        end
        @(negedge clk);
        checks++;
        if ({busy, done, err, res_we, found} !== 5'b0 || worker_start !== 1'b1 ||
            res_word !== 32'h0 || found_nonce !== 4'h0 || worker_nonce !== 4'h0 ||
            worker_hi !== hash_t'(0)) begin
            errors++;
            $display("FAIL reset_values got busy=%b done=%b err=%b we=%b found=%b start=%b want 0 0 0 0 0 1",
                     busy, done, err, res_we, found, worker_start);
        end
        @(posedge clk); #1; go = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || worker_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_go_ignored got busy=%b start=%b want 0 1", busy, worker_start);
        end
    endtask

    task automatic test_full_job();
        int cyc; bit sd, f; logic [3:0] fn;
        tail_t tl;
        int w0;
        tl = {32'h1a2b3c4d, 32'h5e6f7081, 32'h92a3b4c5};
        push_job(SHA256_IV, tl, 32'h2000_0000, f, fn);
        w0 = we_cnt;
        run_job(SHA256_IV, tl, 32'h2000_0000, 0, 0, cyc, sd);
        checks++;
        if (!sd || cyc != 137 * NN + 1) begin
            errors++;
            $display("FAIL full_done_cycle got=%0d seen=%0d want=%0d", cyc, sd, 137 * NN + 1);
        end
        checks++;
        if (we_cnt - w0 != NN || sb.size() != 0) begin
            errors++;
            $display("FAIL full_write_count got=%0d left=%0d want=%0d", we_cnt - w0, sb.size(), NN);
        end
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || found !== f || (f && found_nonce !== fn)) begin
            errors++;
            $display("FAIL full_done_state got busy=%b err=%b found=%b fn=%0d want 1 0 %b %0d",
                     busy, err, found, found_nonce, f, fn);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_target_match();
        int cyc; bit sd, f; logic [3:0] fn;
        hash_t mid; tail_t tl;
        logic [31:0] tgs [3];
        mid = ~SHA256_IV;
        tl  = {32'hdeadbeef, 32'h0badf00d, 32'h13579bdf};
        tgs[0] = 32'hFFFF_FFFF; tgs[1] = 32'h0; tgs[2] = h0_of(mid, tl, 5);
        for (int k = 0; k < 3; k++) begin
            push_job(mid, tl, tgs[k], f, fn);
            if (k == 0) begin
                checks++;
                if (!f || fn !== 4'd0) begin
                    errors++;
                    $display("FAIL target_model_max got=%b/%0d want 1/0", f, fn);
                end
            end
            run_job(mid, tl, tgs[k], 0, 0, cyc, sd);
            checks++;
            if (!sd || found !== f || (f && found_nonce !== fn)) begin
                errors++;
                $display("FAIL target_%0d got found=%b fn=%0d want %b %0d", k, found, found_nonce, f, fn);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc, w0; bit sd, f; logic [3:0] fn;
        tail_t tl;
        tl = {32'h11111111, 32'h22222222, 32'h33333333};
        stub_lat = 100000;
        w0 = we_cnt;
        run_job(SHA256_IV, tl, 32'hFFFF_FFFF, 0, 0, cyc, sd);
        checks++;
        if (!sd || cyc != 81 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort got cyc=%0d seen=%0d err=%b want 81 1 1", cyc, sd, err);
        end
        checks++;
        if (we_cnt != w0 || found !== 1'b0) begin
            errors++;
            $display("FAIL timeout_no_write got writes=%0d found=%b want 0 0", we_cnt - w0, found);
        end
        stub_lat = 67;
        push_job(SHA256_IV, tl, 32'h0, f, fn);
        run_job(SHA256_IV, tl, 32'h0, 0, 0, cyc, sd);
        checks++;
        if (!sd || err !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL timeout_err_clear got err=%b seen=%0d left=%0d want 0 1 0", err, sd, sb.size());
        end
    endtask

    task automatic test_busy_go();
        int cyc; bit sd, f; logic [3:0] fn;
        hash_t mid; tail_t tl;
        mid = {8{32'hc001d00d}};
        tl  = {32'h0, 32'hffffffff, 32'h80000000};
        push_job(mid, tl, 32'h8000_0000, f, fn);
        run_job(mid, tl, 32'h8000_0000, 10, 0, cyc, sd);
        checks++;
        if (!sd || cyc != 137 * NN + 1 || sb.size() != 0 || found !== f || (f && found_nonce !== fn)) begin
            errors++;
            $display("FAIL busy_go_ignored got cyc=%0d left=%0d found=%b want %0d 0 %b",
                     cyc, sb.size(), found, 137 * NN + 1, f);
        end
    endtask

    task automatic test_finish_at_timeout();
        int cyc; bit sd, f; logic [3:0] fn;
        tail_t tl;
        tl = {32'h44444444, 32'h55555555, 32'h66666666};
        stub_lat = 79;
        push_job(SHA256_IV, tl, 32'h4000_0000, f, fn);
        run_job(SHA256_IV, tl, 32'h4000_0000, 0, 0, cyc, sd);
        stub_lat = 67;
        checks++;
        if (!sd || cyc != 161 * NN + 1 || err !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL finish_at_timeout got cyc=%0d err=%b left=%0d want %0d 0 0",
                     cyc, err, sb.size(), 161 * NN + 1);
        end
    endtask

    task automatic test_reset_mid_job();
        int cyc, w0; bit sd, f; logic [3:0] fn;
        hash_t mid; tail_t tl;
        mid = {SHA256_IV[3:0], SHA256_IV[7:4]};
        tl  = {32'h77777777, 32'h88888888, 32'h99999999};
        push_job(mid, tl, 32'hFFFF_FFFF, f, fn);
        run_job(mid, tl, 32'hFFFF_FFFF, 0, 3 * 137 + 68 + 10, cyc, sd);
        checks++;
        if ({busy, done, err, res_we, found} !== 5'b0 || worker_start !== 1'b1 || worker_nonce !== 4'h0) begin
            errors++;
            $display("FAIL midreset_values got busy=%b done=%b err=%b we=%b found=%b start=%b nonce=%0d",
                     busy, done, err, res_we, found, worker_start, worker_nonce);
        end
        checks++;
        if (sb.size() != NN - 3) begin
            errors++;
            $display("FAIL midreset_writes got remaining=%0d want=%0d", sb.size(), NN - 3);
        end
        sb.delete();
        w0 = we_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1; reset_n = 1'b1;
        checks++;
        if (we_cnt != w0) begin
            errors++;
            $display("FAIL midreset_partial_write got=%0d want=0", we_cnt - w0);
        end
        push_job(mid, tl, 32'hFFFF_FFFF, f, fn);
        run_job(mid, tl, 32'hFFFF_FFFF, 0, 0, cyc, sd);
        checks++;
        if (!sd || cyc != 137 * NN + 1 || sb.size() != 0 || found !== 1'b1 || found_nonce !== 4'd0) begin
            errors++;
            $display("FAIL midreset_restart got cyc=%0d left=%0d found=%b fn=%0d want %0d 0 1 0",
                     cyc, sb.size(), found, found_nonce, 137 * NN + 1);
        end
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_target_match();
        test_timeout();
        test_busy_go();
        test_finish_at_timeout();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_nonce_scheduler.md
Name: sha256_nonce_scheduler

Overview:
- Sequences one SHA-256 worker through the per-nonce phase-2 and phase-3 passes of the Bitcoin double hash.
- Takes the phase-1 midstate and the three message-tail words, and sweeps nonces 0..NUM_NONCES-1.
- For each nonce: runs phase 2, feeds the phase-2 digest back as phase-3 input, and writes final digest word H0 to the result interface.
- Also flags the first nonce whose H0 is at or below a target, and guards each worker pass with a watchdog.

Parameters:
NUM_NONCES, 16, number of nonces swept per job (1..16; the worker nonce is 4 bits)
TIMEOUT, 80, maximum cycles to wait for worker finish in one pass before abort

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
go  in  1  single-cycle job start pulse
midstate  in  32x8  phase-1 digest; sampled on an accepted go
msg_tail  in  32x3  message words 16..18; sampled on an accepted go
target  in  32  H0 threshold; sampled on an accepted go
busy  out  1  high from accepted go until done
done  out  1  one-cycle pulse at job end
err  out  1  sticky timeout flag; cleared by the next accepted go
worker_start  out  1  worker hold/restart control
worker_phase_sel  out  1  0 = phase 2, 1 = phase 3
worker_nonce  out  4  current nonce
worker_hi  out  32x8  worker chaining input
worker_msg_tail  out  32x3  latched message tail
worker_ho  in  32x8  worker digest
worker_finish  in  1  worker one-cycle done pulse
res_we  out  1  result write strobe
res_idx  out  4  result index (= nonce)
res_word  out  32  final H0 for res_idx
found  out  1  at least one H0 <= target in the current job
found_nonce  out  4  first qualifying nonce

Behaviour:
- Reset values: busy, done, err, res_we, found = 0; worker_start = 1; all data registers = 0; state = IDLE.
- States and transitions:
  - IDLE: go latches midstate, msg_tail and target; clears nonce, err, found and the watchdog; moves to P2_RUN. Other inputs are ignored.
  - P2_RUN: on worker_finish, latch worker_ho into the p2 registers and move to P3_RUN.
  - P3_RUN: on worker_finish, latch worker_ho[0] into res_word and move to WRITE.
  - WRITE: assert res_we for one cycle. If nonce == NUM_NONCES-1, move to DONE; else increment nonce and move to P2_RUN.
  - DONE: done = 1 for one cycle, then IDLE.
- worker_start is combinational:
  - 0 only when state is P2_RUN or P3_RUN and worker_finish = 0.
  - 1 otherwise, including the finish cycle. This keeps the worker parked in its IDLE and prevents an auto-relaunch.
- worker_phase_sel = (state == P3_RUN).
- worker_hi is the latched midstate in P2_RUN and the p2 registers in P3_RUN. Both sources are held stable for the whole pass.
- worker_nonce and worker_msg_tail are stable from job start and change only in WRITE.
- Timing with the nominal 67-cycle worker (finish arrives 67 cycles after the first start-low cycle):
  - 68 cycles per pass, 137 cycles per nonce.
  - done asserts 137*NUM_NONCES+1 cycles after go.
- Found logic, evaluated in WRITE:
  - If found = 0 and res_word <= target (unsigned 32-bit compare), set found = 1 and found_nonce = nonce.
  - Later matches are ignored.
- Watchdog:
  - Counts cycles in P2_RUN/P3_RUN and resets on each state entry.
  - When the count reaches TIMEOUT without worker_finish: set err = 1 and go to DONE.
  - No res_we for the aborted nonce; found and found_nonce are kept.
- Simultaneous events:
  - A worker_finish on the same cycle the count reaches TIMEOUT counts as a finish, not a timeout.
  - A worker_finish outside P2_RUN/P3_RUN is ignored.
- Reset mid-job: returns to the reset state immediately. worker_start = 1 holds the worker in its own reset path. No partial result write.
- busy = (state != IDLE); it is still 1 during DONE.

Decomposition:
- Package sha256_pkg holds:
  - the state enum;
  - IV constants (shared with the worker);
  - a hash_t typedef for a 32x8 digest.
- One sub-module: sha256_pass_watchdog, a loadable down-counter with timeout output and parameter TIMEOUT.
- The sequencer itself stays flat.

Test Plan:
- Reset check: reset_n low for 3 cycles, with go pulsed during reset -> all outputs at reset values and worker_start = 1; go is ignored.
- Full job: NUM_NONCES=16, real sha256_worker, midstate/msg_tail/target from the team golden model -> 16 res_we pulses with res_idx 0..15 and res_word matching golden H0 values; done at cycle 137*16+1 after go.
- Target match: target = 32'hFFFFFFFF -> found = 1, found_nonce = 0. target = 0 -> found = 0. target = golden H0 of nonce 5 (chosen minimal) -> found_nonce = 5.
- Timeout: worker stub that never finishes -> err = 1 and done after exactly 81 cycles; no res_we; the next go clears err.
- Busy behaviour: a second go at cycle 10 of a job -> ignored; the sequence and count are unchanged. Stub finish coincident with timeout -> treated as finish, err = 0.
- Reset mid-job: reset_n low during P3_RUN of nonce 3 -> outputs return to reset values with no res_we. A new go then restarts from nonce 0.
